// File: rtl/cla_adder_seq_arbiter.sv
// cla_adder_seq_arbiter
// Time-shares one external 16-bit combinational adder among NREQ requesters.
// A round-robin arbiter accepts one WIDTH-bit operation at a time, latches the
// operands, then runs WIDTH/16 adder passes low slice first, with the carry
// chained through a register. The result goes out on a valid/ready response
// channel tagged with the requester index.
// Optional build macro: CLA_ADDER_SEQ_SUB_EN adds req_op (1 = subtract, a - b).
module cla_adder_seq_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
`ifdef CLA_ADDER_SEQ_SUB_EN
  input  logic [NREQ-1:0]       req_op,
`endif
  output logic [15:0]           adder_a,
  output logic [15:0]           adder_b,
  output logic                  adder_cin,
  input  logic [15:0]           adder_sum,
  input  logic                  adder_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  localparam int unsigned S  = WIDTH / 16;
  localparam int unsigned KW = (S > 1) ? $clog2(S) : 1;
  localparam int unsigned PW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_chk_nreq
    $error("cla_adder_seq_arbiter: NREQ must be in 2..8");
  end
  if ((WIDTH % 16) != 0 || WIDTH < 16 || WIDTH > 64) begin : g_chk_width
    $error("cla_adder_seq_arbiter: WIDTH must be a multiple of 16 in 16..64");
  end
  if (IDW < PW) begin : g_chk_idw
    $error("cla_adder_seq_arbiter: IDW too narrow for NREQ");
  end

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state_q;
  state_t           state_d;

  // arbitration
  logic [PW-1:0]    rr_q;
  logic [PW-1:0]    sel;
  logic [PW:0]      pos;
  logic             any_valid;
  logic             accept;

  // operands of the selected requester
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic             cin_sel;

  // latched operation and running result
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [IDW-1:0]   id_q;
  logic [KW-1:0]    k_q;
  logic             carry_q;
  logic [WIDTH-1:0] res_q;
  logic             cout_q;

  // current slice view
  logic [15:0]      a_slice;
  logic [15:0]      b_slice;
  logic             last_slice;
  logic             sub_c;

`ifdef CLA_ADDER_SEQ_SUB_EN
  logic             op_sel;
  logic             op_q;
  assign sub_c = op_q;
`else
  assign sub_c = 1'b0;
`endif

  // Round-robin search: first valid requester at or above rr_q, wrapping.
  always_comb begin
    pos       = '0;
    sel       = '0;
    any_valid = 1'b0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      pos = {1'b0, rr_q} + (PW+1)'(j);
      if (pos >= (PW+1)'(NREQ)) begin
        pos = pos - (PW+1)'(NREQ);
      end
      if (!any_valid && req_valid[pos[PW-1:0]]) begin
        any_valid = 1'b1;
        sel       = pos[PW-1:0];
      end
    end
  end

  // Operand mux for the selected requester.
  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    cin_sel = 1'b0;
`ifdef CLA_ADDER_SEQ_SUB_EN
    op_sel  = 1'b0;
`endif
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (sel == PW'(i)) begin
        a_sel   = req_a[i*WIDTH +: WIDTH];
        b_sel   = req_b[i*WIDTH +: WIDTH];
        cin_sel = req_cin[i];
`ifdef CLA_ADDER_SEQ_SUB_EN
        op_sel  = req_op[i];
`endif
      end
    end
  end

  // Slice k of the latched operands feeds the shared adder.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int unsigned s = 0; s < S; s++) begin
      if (k_q == KW'(s)) begin
        a_slice = a_q[16*s +: 16];
        b_slice = b_q[16*s +: 16];
      end
    end
  end

  assign last_slice = (k_q == KW'(S-1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and control outputs; adder ports are only driven in EXEC.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    req_ready = '0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          accept         = 1'b1;
          // gated by rst_n so a held request shows no accept while in reset
          req_ready[sel] = rst_n;
          state_d        = EXEC;
        end
      end
      EXEC: begin
        busy    = 1'b1;
        adder_a = a_slice;
        adder_b = sub_c ? ~b_slice : b_slice;
        if (k_q == '0) begin
          adder_cin = sub_c ? 1'b1 : cin_q;
        end else begin
          adder_cin = carry_q;
        end
        if (last_slice) begin
          state_d = RESP;
        end
      end
      RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch at accept, slice-by-slice result and carry chaining in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      id_q    <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_q   <= a_sel;
        b_q   <= b_sel;
        cin_q <= cin_sel;
        id_q  <= IDW'(sel);
        k_q   <= '0;
        rr_q  <= (sel == PW'(NREQ-1)) ? '0 : sel + 1'b1;
      end
      if (state_q == EXEC) begin
        for (int unsigned s = 0; s < S; s++) begin
          if (k_q == KW'(s)) begin
            res_q[16*s +: 16] <= adder_sum;
          end
        end
        carry_q <= adder_cout;
        if (last_slice) begin
          k_q    <= '0;
          cout_q <= adder_cout;
        end else begin
          k_q <= k_q + 1'b1;
        end
      end
    end
  end

`ifdef CLA_ADDER_SEQ_SUB_EN
  // Operation select latched alongside the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= 1'b0;
    end else if (accept) begin
      op_q <= op_sel;
    end
  end
`endif

  assign rsp_sum  = res_q;
  assign rsp_cout = cout_q;
  assign rsp_id   = id_q;

endmodule

// File: tb/tb_cla_adder_seq_arbiter.sv
`timescale 1ns/1ps
module tb_cla_adder_seq_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 3;
  localparam int S     = WIDTH / 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ-1:0]       req_cin = '0;
  logic [NREQ-1:0]       op_drv = '0;
  logic [15:0]           adder_a, adder_b, adder_sum;
  logic                  adder_cin, adder_cout;
  logic                  rsp_valid, rsp_cout, busy;
  logic                  rsp_ready = 1'b0;
  logic [WIDTH-1:0]      rsp_sum;
  logic [IDW-1:0]        rsp_id;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          mptr     = 0;

  always #5 clk = ~clk;

  // shared 16-bit adder
  assign {adder_cout, adder_sum} = 17'(adder_a) + 17'(adder_b) + 17'(adder_cin);

  cla_adder_seq_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
`ifdef CLA_ADDER_SEQ_SUB_EN
    .req_op(op_drv),
`endif
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_sum(adder_sum), .adder_cout(adder_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id), .busy(busy)
  );

  // reference: {carry, sum} of the whole-width operation
  function automatic logic [WIDTH:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic cin, input logic op);
`ifdef CLA_ADDER_SEQ_SUB_EN
    if (op) return {1'b1, a} - {1'b0, b};
`endif
    return {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int j = 0; j < NREQ; j++) if (v[(ptr + j) % NREQ]) return (ptr + j) % NREQ;
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_w();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[WIDTH-1:0];
  endfunction

  function automatic logic rnd_op();
`ifdef CLA_ADDER_SEQ_SUB_EN
    return 1'($urandom_range(1, 0));
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic op);
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
    req_cin[id] = cin;
    op_drv[id]  = op;
  endtask

  function automatic logic [WIDTH:0] ref_of(input int id);
    return ref_op(req_a[id*WIDTH +: WIDTH], req_b[id*WIDTH +: WIDTH], req_cin[id], op_drv[id]);
  endfunction

  task automatic wait_rsp(output bit to);
    int w;
    w = 0;
    while (!rsp_valid && w < 20) begin tick(); w++; end
    to = !rsp_valid;
  endtask

  // single operation from one requester with rsp_ready high
  task automatic run_op(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic op,
                        output logic [WIDTH:0] res, output logic [IDW-1:0] rid,
                        output int lat, output bit to);
    int w;
    to = 1'b0; lat = 0; w = 0;
    set_req(id, a, b, cin, op);
    rsp_ready = 1'b1;
    req_valid[id] = 1'b1;
    #1;
    while (!req_ready[id] && w < 20) begin tick(); w++; end
    if (!req_ready[id]) to = 1'b1;
    tick();
    req_valid[id] = 1'b0;
    set_req(id, rnd_w(), rnd_w(), ~cin, ~op);
    #1;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
    if (!rsp_valid) to = 1'b1;
    res = {rsp_cout, rsp_sum};
    rid = rsp_id;
    tick();
    mptr = (id + 1) % NREQ;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '1;
    repeat (3) tick();
    n_checks++; if (req_ready !== '0) $display("FAIL rst_req_ready: got %b want 0", req_ready); else n_pass++;
    n_checks++; if ({adder_a, adder_b, adder_cin} !== '0) $display("FAIL rst_adder: got %h %h %b want 0", adder_a, adder_b, adder_cin); else n_pass++;
    n_checks++; if ({rsp_valid, rsp_cout, busy} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {rsp_valid, rsp_cout, busy}); else n_pass++;
    n_checks++; if ({rsp_sum, rsp_id} !== '0) $display("FAIL rst_rsp: got %h %h want 0", rsp_sum, rsp_id); else n_pass++;
    req_valid = '0;
    rst_n = 1'b1;
    mptr = 0;
    tick();
    n_checks++; if ({busy, rsp_valid} !== 2'b00) $display("FAIL rst_release_idle: got %b want 00", {busy, rsp_valid}); else n_pass++;
  endtask

  task automatic test_directed();
    set_req(0, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    #1;
    n_checks++; if (req_ready !== 4'b0001) $display("FAIL dir_grant: got %b want 0001", req_ready); else n_pass++;
    tick();
    req_valid = '0;
    #1;
    n_checks++; if ({req_ready, busy, rsp_valid} !== 6'b0000_10) $display("FAIL dir_exec0_flags: got %b want 000010", {req_ready, busy, rsp_valid}); else n_pass++;
    n_checks++; if ({adder_a, adder_b, adder_cin} !== {16'hFFFF, 16'h0001, 1'b0}) $display("FAIL dir_slice0: got %h %h %b want ffff 0001 0", adder_a, adder_b, adder_cin); else n_pass++;
    tick();
    n_checks++; if ({adder_a, adder_b, adder_cin, rsp_valid} !== {16'h0000, 16'h0000, 1'b1, 1'b0}) $display("FAIL dir_slice1: got %h %h %b v=%b want 0000 0000 1 v=0", adder_a, adder_b, adder_cin, rsp_valid); else n_pass++;
    tick();
    n_checks++; if (rsp_valid !== 1'b1) $display("FAIL dir_latency: rsp_valid got %b want 1", rsp_valid); else n_pass++;
    n_checks++; if ({rsp_cout, rsp_sum, rsp_id} !== {1'b0, 32'h00010000, 3'd0}) $display("FAIL dir_result: got %b %h %0d want 0 00010000 0", rsp_cout, rsp_sum, rsp_id); else n_pass++;
    n_checks++; if ({adder_a, adder_b, adder_cin} !== '0) $display("FAIL dir_adder_idle: got %h %h %b want 0", adder_a, adder_b, adder_cin); else n_pass++;
    tick();
    n_checks++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL dir_done: got %b want 00", {rsp_valid, busy}); else n_pass++;
    mptr = 1;
  endtask

  task automatic test_arith();
    logic [WIDTH:0] res, exp;
    logic [IDW-1:0] rid;
    logic [WIDTH-1:0] a, b;
    logic c, o;
    int lat, id;
    bit to;
    run_op(1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, res, rid, lat, to);
    n_checks++; if ({to, res, rid} !== {1'b0, 1'b1, 32'h00000000, 3'd1}) $display("FAIL arith_wrap: got to=%b %h id=%0d want 1_00000000 id=1", to, res, rid); else n_pass++;
    run_op(3, 32'h12345678, 32'h11111111, 1'b1, 1'b0, res, rid, lat, to);
    n_checks++; if ({to, res, rid} !== {1'b0, 1'b0, 32'h2345678A, 3'd3}) $display("FAIL arith_cin: got to=%b %h id=%0d want 0_2345678a id=3", to, res, rid); else n_pass++;
`ifdef CLA_ADDER_SEQ_SUB_EN
    run_op(0, 32'd5, 32'd7, 1'b0, 1'b1, res, rid, lat, to);
    n_checks++; if ({to, res} !== {1'b0, 1'b0, 32'hFFFFFFFE}) $display("FAIL sub_borrow: got to=%b %h want 0_fffffffe", to, res); else n_pass++;
    run_op(2, 32'd7, 32'd5, 1'b1, 1'b1, res, rid, lat, to);
    n_checks++; if ({to, res} !== {1'b0, 1'b1, 32'h00000002}) $display("FAIL sub_noborrow: got to=%b %h want 1_00000002", to, res); else n_pass++;
`endif
    for (int n = 0; n < 24; n++) begin
      id = $urandom_range(NREQ - 1, 0);
      a = rnd_w(); b = rnd_w();
      if (n % 4 == 0) b = ~a;
      c = 1'($urandom_range(1, 0));
      o = rnd_op();
      exp = ref_op(a, b, c, o);
      run_op(id, a, b, c, o, res, rid, lat, to);
      n_checks++; if (to !== 1'b0 || lat !== S) $display("FAIL arith_latency[%0d]: got to=%b lat=%0d want lat=%0d", n, to, lat, S); else n_pass++;
      n_checks++; if (res !== exp || rid !== IDW'(id)) $display("FAIL arith_rand[%0d]: got %h id=%0d want %h id=%0d", n, res, rid, exp, id); else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [WIDTH:0] expq[$];
    int idq[$];
    int ng, last_g, cyc, g;
    logic [WIDTH:0] e;
    int ei;
    test_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, rnd_w(), rnd_w(), 1'($urandom_range(1, 0)), rnd_op());
    rsp_ready = 1'b1;
    req_valid = '1;
    ng = 0; last_g = 0; cyc = 0;
    while (ng < 6 && cyc < 80) begin
      #1;
      g = -1;
      if (rsp_valid) begin
        e = expq.pop_front(); ei = idq.pop_front();
        n_checks++; if ({rsp_cout, rsp_sum} !== e || rsp_id !== IDW'(ei)) $display("FAIL rr_rsp: got %h id=%0d want %h id=%0d", {rsp_cout, rsp_sum}, rsp_id, e, ei); else n_pass++;
      end
      if (req_ready !== '0) begin
        g = ng % NREQ;
        n_checks++; if (req_ready !== NREQ'(1 << g)) $display("FAIL rr_order[%0d]: got %b want %b", ng, req_ready, NREQ'(1 << g)); else n_pass++;
        if (ng > 0) begin
          n_checks++; if (cyc - last_g !== S + 2) $display("FAIL rr_spacing[%0d]: got %0d want %0d", ng, cyc - last_g, S + 2); else n_pass++;
        end
        expq.push_back(ref_of(g)); idq.push_back(g);
        last_g = cyc; ng++;
      end
      tick(); cyc++;
      if (g >= 0) set_req(g, rnd_w(), rnd_w(), 1'($urandom_range(1, 0)), rnd_op());
    end
    req_valid = '0;
    n_checks++; if (ng !== 6) $display("FAIL rr_grants: got %0d want 6", ng); else n_pass++;
    while (expq.size() > 0 && cyc < 200) begin
      #1;
      if (rsp_valid) begin
        e = expq.pop_front(); ei = idq.pop_front();
        n_checks++; if ({rsp_cout, rsp_sum} !== e || rsp_id !== IDW'(ei)) $display("FAIL rr_rsp: got %h id=%0d want %h id=%0d", {rsp_cout, rsp_sum}, rsp_id, e, ei); else n_pass++;
      end
      tick(); cyc++;
    end
    n_checks++; if (expq.size() !== 0) $display("FAIL rr_drain: got %0d pending want 0", expq.size()); else n_pass++;
    mptr = 6 % NREQ;
  endtask

  task automatic test_backpressure();
    logic [WIDTH:0] exp1, exp2;
    int p;
    bit to;
    set_req(1, rnd_w(), rnd_w(), 1'($urandom_range(1, 0)), rnd_op());
    exp1 = ref_of(1);
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    n_checks++; if (req_ready !== 4'b0010) $display("FAIL bp_grant1: got %b want 0010", req_ready); else n_pass++;
    tick();
    mptr = 2;
    set_req(0, rnd_w(), rnd_w(), 1'($urandom_range(1, 0)), rnd_op());
    set_req(3, rnd_w(), rnd_w(), 1'($urandom_range(1, 0)), rnd_op());
    req_valid = 4'b1001;
    p = pick(req_valid, mptr);
    exp2 = ref_of(p);
    #1;
    wait_rsp(to);
    n_checks++; if (to !== 1'b0) $display("FAIL bp_timeout: rsp_valid never rose"); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if ({rsp_valid, rsp_cout, rsp_sum} !== {1'b1, exp1} || rsp_id !== IDW'(1)) $display("FAIL bp_hold[%0d]: got v=%b %h id=%0d want v=1 %h id=1", c, rsp_valid, {rsp_cout, rsp_sum}, rsp_id, exp1); else n_pass++;
      n_checks++; if (req_ready !== '0) $display("FAIL bp_no_grant[%0d]: got %b want 0", c, req_ready); else n_pass++;
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== '0) $display("FAIL bp_hs_cycle: got %b want 0", req_ready); else n_pass++;
    tick();
    n_checks++; if (req_ready !== NREQ'(1 << p) || rsp_valid !== 1'b0) $display("FAIL bp_grant_after: got %b v=%b want %b v=0", req_ready, rsp_valid, NREQ'(1 << p)); else n_pass++;
    tick();
    mptr = (p + 1) % NREQ;
    req_valid = '0;
    #1;
    wait_rsp(to);
    n_checks++; if (to !== 1'b0 || {rsp_cout, rsp_sum} !== exp2 || rsp_id !== IDW'(p)) $display("FAIL bp_second: got to=%b %h id=%0d want %h id=%0d", to, {rsp_cout, rsp_sum}, rsp_id, exp2, p); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [WIDTH:0] res, exp;
    logic [WIDTH-1:0] a;
    logic [IDW-1:0] rid;
    int lat;
    bit to;
    a = rnd_w();
    run_op(2, a, rnd_w(), 1'b0, 1'b0, res, rid, lat, to);
    n_checks++; if (to !== 1'b0 || rid !== IDW'(2)) $display("FAIL rm_pre: got to=%b id=%0d want id=2", to, rid); else n_pass++;
    set_req(2, a, rnd_w(), 1'($urandom_range(1, 0)), rnd_op());
    set_req(3, rnd_w(), rnd_w(), 1'($urandom_range(1, 0)), rnd_op());
    req_valid = 4'b0100;
    #1;
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL rm_grant: got %b want 0100", req_ready); else n_pass++;
    tick();
    tick();
    n_checks++; if (busy !== 1'b1 || adder_a !== a[31:16]) $display("FAIL rm_slice1: got busy=%b a=%h want busy=1 a=%h", busy, adder_a, a[31:16]); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({req_ready, adder_a, adder_b, adder_cin, rsp_valid, rsp_cout, busy} !== '0) $display("FAIL rm_async_ctrl: got rdy=%b %h %h %b v=%b c=%b busy=%b want 0", req_ready, adder_a, adder_b, adder_cin, rsp_valid, rsp_cout, busy); else n_pass++;
    n_checks++; if ({rsp_sum, rsp_id} !== '0) $display("FAIL rm_async_rsp: got %h id=%0d want 0", rsp_sum, rsp_id); else n_pass++;
    mptr = 0;
    tick(); tick();
    n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rm_no_rsp: got %b want 0", rsp_valid); else n_pass++;
    rst_n = 1'b1;
    req_valid = 4'b1100;
    #1;
    n_checks++; if (req_ready !== NREQ'(1 << pick(req_valid, mptr))) $display("FAIL rm_regrant: got %b want %b", req_ready, NREQ'(1 << pick(req_valid, mptr))); else n_pass++;
    exp = ref_of(2);
    tick();
    mptr = 3;
    req_valid = 4'b1000;
    #1;
    wait_rsp(to);
    n_checks++; if (to !== 1'b0 || {rsp_cout, rsp_sum} !== exp || rsp_id !== IDW'(2)) $display("FAIL rm_result: got to=%b %h id=%0d want %h id=2", to, {rsp_cout, rsp_sum}, rsp_id, exp); else n_pass++;
    exp = ref_of(3);
    tick();
    n_checks++; if (req_ready !== 4'b1000) $display("FAIL rm_next: got %b want 1000", req_ready); else n_pass++;
    tick();
    mptr = 0;
    req_valid = '0;
    #1;
    wait_rsp(to);
    n_checks++; if (to !== 1'b0 || {rsp_cout, rsp_sum} !== exp || rsp_id !== IDW'(3)) $display("FAIL rm_result3: got to=%b %h id=%0d want %h id=3", to, {rsp_cout, rsp_sum}, rsp_id, exp); else n_pass++;
    tick();
  endtask

  task automatic test_random_traffic();
    // model: idle, S exec cycles, then response until handshake
    bit in_idle, in_resp;
    int exec_left, p, g;
    logic [WIDTH:0] exp_res;
    int exp_id;
    logic [NREQ-1:0] exp_rdy;
    in_idle = 1'b1; in_resp = 1'b0; exec_left = 0; exp_res = '0; exp_id = 0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (cyc >= 600) begin
        req_valid = '0;
        if (in_idle) break;
      end
      rsp_ready = 1'($urandom_range(1, 0));
      #1;
      p = pick(req_valid, mptr);
      exp_rdy = (in_idle && p >= 0) ? NREQ'(1 << p) : '0;
      n_checks++; if (req_ready !== exp_rdy) $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, req_ready, exp_rdy); else n_pass++;
      n_checks++; if (rsp_valid !== in_resp) $display("FAIL rnd_valid[%0d]: got %b want %b", cyc, rsp_valid, in_resp); else n_pass++;
      if (in_resp) begin
        n_checks++; if ({rsp_cout, rsp_sum} !== exp_res || rsp_id !== IDW'(exp_id)) $display("FAIL rnd_rsp[%0d]: got %h id=%0d want %h id=%0d", cyc, {rsp_cout, rsp_sum}, rsp_id, exp_res, exp_id); else n_pass++;
      end
      g = -1;
      if (in_idle && p >= 0) begin
        exp_res = ref_of(p); exp_id = p; g = p;
        mptr = (p + 1) % NREQ;
        in_idle = 1'b0; exec_left = S;
      end else if (exec_left > 0) begin
        exec_left--;
        if (exec_left == 0) in_resp = 1'b1;
      end else if (in_resp && rsp_ready) begin
        in_resp = 1'b0; in_idle = 1'b1;
      end
      tick();
      if (g >= 0) req_valid[g] = 1'b0;
      if (cyc < 600) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!req_valid[i] && $urandom_range(2, 0) == 0) begin
            set_req(i, rnd_w(), rnd_w(), 1'($urandom_range(1, 0)), rnd_op());
            req_valid[i] = 1'b1;
          end else if (req_valid[i] && $urandom_range(19, 0) == 0) begin
            req_valid[i] = 1'b0;
          end
        end
      end
    end
    #1;
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL rnd_drain: got busy=%b v=%b want 0 0", busy, rsp_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_arith();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random_traffic();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "time limit");
  end

endmodule
